writeback_arbiter: RTL and testbench

// - Final pipeline stage, directly upstream of the register file write port.
// - Merges two result streams onto the single write port: ALU results and load results from the memory unit.
// - Buffers load results in a small FIFO and arbitrates between the streams with an anti-starvation counter.
// - Drives write_params/data_rd from registers; the register file commits on the following posedge.

---
 rtl/writeback_arbiter_if.sv | 28 ++
 rtl/writeback_arbiter.sv | 65 ++++++
 tb/tb_writeback_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU/load result handshakes and the register-file write port
interface writeback_arbiter_if #(
  parameter int LOAD_FIFO_DEPTH = 2
);
  typedef struct packed {
    logic       write_enable;
    logic [4:0] addr_rd;
  } reg_file_write_params_t;
  logic                               alu_valid;
  logic                               alu_ready;
  logic [4:0]                         alu_rd;
  logic [31:0]                        alu_data;
  logic                               mem_valid;
  logic                               mem_ready;
  logic [4:0]                         mem_rd;
  logic [31:0]                        mem_data;
  reg_file_write_params_t             write_params;
  logic [31:0]                        data_rd;
  logic [$clog2(LOAD_FIFO_DEPTH):0]   load_fifo_count;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, write_params, data_rd, load_fifo_count
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, write_params, data_rd, load_fifo_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU results and FIFO-buffered load results onto the register-file write port
module writeback_arbiter #(
  parameter int LOAD_FIFO_DEPTH = 2,
  parameter int MAX_ALU_STALL   = 3
) (
  input logic                clock,
  input logic                reset,
  writeback_arbiter_if.slave wb
);
  localparam int AW = $clog2(LOAD_FIFO_DEPTH);
  localparam int SW = $clog2(MAX_ALU_STALL + 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(LOAD_FIFO_DEPTH);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_ALU_STALL);
  typedef enum logic [1:0] {GRANT_NONE, GRANT_ALU, GRANT_LOAD} grant_t;
  logic [4:0]    fifo_rd   [LOAD_FIFO_DEPTH];
  logic [31:0]   fifo_data [LOAD_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [SW-1:0] stall_cnt;
  grant_t        grant;
  logic          empty, push, pop;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  assign empty              = count == '0;
  assign wb.mem_ready       = count != FULL;
  assign wb.alu_ready       = grant == GRANT_ALU;
  assign wb.load_fifo_count = count;
  assign push               = wb.mem_valid && wb.mem_ready;
  assign pop                = grant == GRANT_LOAD;
  // Loads win until the ALU has lost MAX_ALU_STALL cycles in a row
  always_comb begin
    grant    = reset ? GRANT_NONE
             : (!empty && stall_cnt < STALL_MAX) ? GRANT_LOAD
             : wb.alu_valid ? GRANT_ALU
             : !empty ? GRANT_LOAD : GRANT_NONE;
    sel_rd   = (grant == GRANT_LOAD) ? fifo_rd[rd_ptr] : wb.alu_rd;
    sel_data = (grant == GRANT_LOAD) ? fifo_data[rd_ptr] : wb.alu_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      stall_cnt       <= '0;
      wb.write_params <= '0;
      wb.data_rd      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count     <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      stall_cnt <= (wb.alu_valid && pop) ? stall_cnt + SW'(stall_cnt != STALL_MAX) : '0;
      wb.write_params.write_enable <= grant != GRANT_NONE && sel_rd != '0;
      if (grant != GRANT_NONE) begin
        wb.write_params.addr_rd <= sel_rd;
        wb.data_rd              <= sel_data;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= wb.mem_rd;
      fifo_data[wr_ptr] <= wb.mem_data;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed vector table, reset corner cases and a queue-model random run
module tb_writeback_arbiter;
  localparam int DEPTH = 2;
  localparam int MAXS  = 3;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;
  writeback_arbiter_if #(.LOAD_FIFO_DEPTH(DEPTH)) wb();
  writeback_arbiter #(.LOAD_FIFO_DEPTH(DEPTH), .MAX_ALU_STALL(MAXS)) dut (
    .clock(clock),
    .reset(reset),
    .wb(wb)
  );
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] adata;
    logic mv; logic [4:0] mrd; logic [31:0] mdata;
    logic e_ar, e_mr, e_we; logic [4:0] e_addr; logic [31:0] e_data; logic [31:0] e_cnt;
  } vec_t;
  vec_t vt[16];
  function automatic vec_t mk(int av, int ard, int adata, int mv, int mrd, int mdata,
                              int ar, int mr, int we, int addr, int data, int cnt);
    vec_t v;
    v.av = 1'(av); v.ard = 5'(ard); v.adata = 32'(adata);
    v.mv = 1'(mv); v.mrd = 5'(mrd); v.mdata = 32'(mdata);
    v.e_ar = 1'(ar); v.e_mr = 1'(mr); v.e_we = 1'(we);
    v.e_addr = 5'(addr); v.e_data = 32'(data); v.e_cnt = 32'(cnt);
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(logic av, logic [4:0] ard, logic [31:0] adata,
                       logic mv, logic [4:0] mrd, logic [31:0] mdata);
    wb.alu_valid = av; wb.alu_rd = ard; wb.alu_data = adata;
    wb.mem_valid = mv; wb.mem_rd = mrd; wb.mem_data = mdata;
  endtask
  task automatic check_regs(string tag, logic we, logic [4:0] addr, logic [31:0] data, logic [31:0] cnt);
    chk($sformatf("%s we", tag), 32'(wb.write_params.write_enable), 32'(we));
    chk($sformatf("%s addr", tag), 32'(wb.write_params.addr_rd), 32'(addr));
    chk($sformatf("%s data", tag), wb.data_rd, data);
    chk($sformatf("%s count", tag), 32'(wb.load_fifo_count), cnt);
  endtask
  // Starts and ends one time unit after a rising edge
  task automatic apply(vec_t v, int id);
    drive(v.av, v.ard, v.adata, v.mv, v.mrd, v.mdata);
    #3;
    chk($sformatf("vec%0d alu_ready", id), 32'(wb.alu_ready), 32'(v.e_ar));
    chk($sformatf("vec%0d mem_ready", id), 32'(wb.mem_ready), 32'(v.e_mr));
    @(posedge clock); #1;
    check_regs($sformatf("vec%0d", id), v.e_we, v.e_addr, v.e_data, v.e_cnt);
  endtask
  task automatic do_reset(string tag);
    reset = 1'b1;
    drive(1'b1, 5'd4, 32'h4444, 1'b1, 5'd6, 32'h6666);
    #3;
    chk($sformatf("%s alu_ready in reset", tag), 32'(wb.alu_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk($sformatf("%s mem_ready", tag), 32'(wb.mem_ready), 32'd1);
    check_regs(tag, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask
  logic        av, mv, hold, e_mr, m_we;
  logic [4:0]  ard, mrd, m_addr;
  logic [31:0] adat, mdat, m_data;
  logic [36:0] q[$];
  int          stall, g;
  initial begin
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,       1, 1, 1, 5, 32'hDEADBEEF, 0);
    vt[1]  = mk(1, 0, 32'h1234, 0, 0, 0,           1, 1, 0, 0, 32'h1234, 0);
    vt[2]  = mk(0, 0, 0, 1, 0, 32'h55,             0, 1, 0, 0, 32'h1234, 1);
    vt[3]  = mk(0, 0, 0, 0, 0, 0,                  0, 1, 0, 0, 32'h55, 0);
    vt[4]  = mk(0, 0, 0, 1, 1, 32'h11,             0, 1, 0, 0, 32'h55, 1);
    vt[5]  = mk(0, 0, 0, 1, 2, 32'h22,             0, 1, 1, 1, 32'h11, 1);
    vt[6]  = mk(0, 0, 0, 1, 3, 32'h33,             0, 1, 1, 2, 32'h22, 1);
    vt[7]  = mk(0, 0, 0, 0, 0, 0,                  0, 1, 1, 3, 32'h33, 0);
    vt[8]  = mk(1, 7, 32'h77, 1, 8, 32'h88,        1, 1, 1, 7, 32'h77, 1);
    vt[9]  = mk(1, 9, 32'h99, 1, 10, 32'hA0,       0, 1, 1, 8, 32'h88, 1);
    vt[10] = mk(1, 9, 32'h99, 1, 11, 32'hB0,       0, 1, 1, 10, 32'hA0, 1);
    vt[11] = mk(1, 9, 32'h99, 1, 12, 32'hC0,       0, 1, 1, 11, 32'hB0, 1);
    vt[12] = mk(1, 9, 32'h99, 1, 13, 32'hD0,       1, 1, 1, 9, 32'h99, 2);
    vt[13] = mk(0, 0, 0, 1, 14, 32'hE0,            0, 0, 1, 12, 32'hC0, 1);
    vt[14] = mk(0, 0, 0, 0, 0, 0,                  0, 1, 1, 13, 32'hD0, 0);
    vt[15] = mk(0, 0, 0, 0, 0, 0,                  0, 1, 0, 13, 32'hD0, 0);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clock); #1;
    do_reset("init");
    for (int i = 0; i < 16; i++) apply(vt[i], i);
    // Build a full FIFO with a write in flight, then reset over it
    for (int i = 8; i <= 12; i++) apply(vt[i], 100 + i);
    do_reset("midop");
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check_regs($sformatf("post_reset%0d", i), 1'b0, 5'd0, 32'd0, 32'd0);
    end
    do_reset("rand");
    q.delete(); stall = 0; hold = 1'b0;
    m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    av = 1'b0; ard = 5'd0; adat = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        av = 1'($urandom_range(0, 1));
        ard = 5'($urandom_range(0, 31));
        adat = $urandom;
      end
      mv = $urandom_range(0, 2) != 0;
      mrd = 5'($urandom_range(0, 31));
      mdat = $urandom;
      drive(av, ard, adat, mv, mrd, mdat);
      e_mr = q.size() != DEPTH;
      g = (q.size() != 0 && stall < MAXS) ? 2 : av ? 1 : (q.size() != 0) ? 2 : 0;
      #3;
      chk($sformatf("rand%0d alu_ready", c), 32'(wb.alu_ready), 32'(g == 1));
      chk($sformatf("rand%0d mem_ready", c), 32'(wb.mem_ready), 32'(e_mr));
      @(posedge clock); #1;
      if (g == 1) begin
        m_we = ard != 5'd0; m_addr = ard; m_data = adat;
      end else if (g == 2) begin
        {m_addr, m_data} = q.pop_front();
        m_we = m_addr != 5'd0;
      end else m_we = 1'b0;
      if (mv && e_mr) q.push_back({mrd, mdat});
      stall = (av && g == 2) ? ((stall < MAXS) ? stall + 1 : stall) : 0;
      hold = av && g != 1;
      check_regs($sformatf("rand%0d", c), m_we, m_addr, m_data, 32'(q.size()));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
